// File: rtl/nios_system_copy_pkg.sv
// Shared definitions for the nios_system copy master: FSM encoding and
// Avalon word constants.
package nios_system_copy_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic [3:0] BYTEENA_ALL = 4'hF;
    localparam int         WORD_BYTES  = 4;

endpackage

// File: rtl/nios_system_copy_fifo.sv
// Synchronous FIFO that stages one read batch before it is written back out.
// Push and pop together on a non-empty FIFO leave the count unchanged.
module nios_system_copy_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_empty,
    output logic             o_full,
    output logic [CNT_W-1:0] o_count
);

    localparam int IDX_W = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [IDX_W-1:0] r_wr_idx;
    logic [IDX_W-1:0] r_rd_idx;
    logic [CNT_W-1:0] r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_idx] <= i_data;
        end
    end

    // Indices wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_idx <= '0;
            r_rd_idx <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_idx <= r_wr_idx + 1'b1;
            if (w_do_pop)  r_rd_idx <= r_rd_idx + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_data  = r_mem[r_rd_idx];
    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == CNT_W'(DEPTH));
    assign o_count = r_count;

endmodule

// File: rtl/nios_system_mem_copy_master.sv
// Avalon-MM copy engine: reads up to FIFO_DEPTH words into a local FIFO,
// writes them to the destination, and repeats until the block is copied.
module nios_system_mem_copy_master
    import nios_system_copy_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int LEN_W      = 16,
    parameter int FIFO_DEPTH = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [LEN_W-1:0]  len,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] m_address,
    output logic              m_read,
    output logic              m_write,
    output logic [3:0]        m_byteenable,
    output logic [31:0]       m_writedata,
    input  logic              m_waitrequest,
    input  logic [31:0]       m_readdata,
    input  logic              m_readdatavalid
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    state_t            r_state;
    state_t            w_next;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [LEN_W-1:0]  r_remaining;
    logic [CNT_W-1:0]  r_batch;
    logic [CNT_W-1:0]  r_issued;
    logic [CNT_W-1:0]  r_received;
    logic [CNT_W-1:0]  w_rcv_next;
    logic [CNT_W-1:0]  w_fifo_count;
    logic [31:0]       w_fifo_head;
    logic              w_fifo_empty;
    logic              w_fifo_full;
    logic              w_start_ok;
    logic              w_rd_accept;
    logic              w_push;
    logic              w_pop;
    logic              w_last_pop;
    logic              r_done;
    logic              w_unused;

    function automatic logic [CNT_W-1:0] f_batch(input logic [LEN_W-1:0] rem);
        if (rem >= LEN_W'(FIFO_DEPTH)) return CNT_W'(FIFO_DEPTH);
        return CNT_W'(rem);
    endfunction

    assign w_unused    = ^{src_addr[1:0], dst_addr[1:0]};
    assign w_start_ok  = (r_state == ST_IDLE) && start && !r_done;
    assign w_rd_accept = m_read && !m_waitrequest;
    assign w_push      = (r_state == ST_RD) && m_readdatavalid;
    assign w_pop       = (r_state == ST_WR) && !m_waitrequest;
    assign w_last_pop  = w_pop && (w_fifo_count == CNT_W'(1));
    assign w_rcv_next  = r_received + CNT_W'(w_push);

    nios_system_copy_fifo #(
        .WIDTH (32),
        .DEPTH (FIFO_DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .i_push  (w_push),
        .i_data  (m_readdata),
        .i_pop   (w_pop),
        .o_data  (w_fifo_head),
        .o_empty (w_fifo_empty),
        .o_full  (w_fifo_full),
        .o_count (w_fifo_count)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= ST_IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (w_start_ok) w_next = (len == '0) ? ST_DONE : ST_RD;
            ST_RD:   if (w_rcv_next == r_batch) w_next = ST_WR;
            ST_WR:   if (w_last_pop) w_next = (r_remaining == '0) ? ST_DONE : ST_RD;
            ST_DONE: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    // done is registered off the DONE state, so busy covers it explicitly.
    always_comb begin
        m_read      = 1'b0;
        m_write     = 1'b0;
        m_address   = '0;
        m_writedata = '0;
        case (r_state)
            ST_RD: begin
                m_read    = (r_issued != r_batch) && !w_fifo_full;
                m_address = r_rd_ptr;
            end
            ST_WR: begin
                m_write     = !w_fifo_empty;
                m_address   = r_wr_ptr;
                m_writedata = w_fifo_head;
            end
            default: ;
        endcase
    end

    assign m_byteenable = BYTEENA_ALL;
    assign busy         = (r_state != ST_IDLE) || r_done;
    assign done         = r_done;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_done      <= 1'b0;
            r_rd_ptr    <= '0;
            r_wr_ptr    <= '0;
            r_remaining <= '0;
            r_batch     <= '0;
            r_issued    <= '0;
            r_received  <= '0;
        end else begin
            r_done <= (r_state == ST_DONE);
            if (w_start_ok) begin
                r_rd_ptr    <= {src_addr[ADDR_W-1:2], 2'b00};
                r_wr_ptr    <= {dst_addr[ADDR_W-1:2], 2'b00};
                r_batch     <= f_batch(len);
                r_remaining <= len - LEN_W'(f_batch(len));
            end else begin
                if (w_rd_accept) r_rd_ptr <= r_rd_ptr + ADDR_W'(WORD_BYTES);
                if (w_pop)       r_wr_ptr <= r_wr_ptr + ADDR_W'(WORD_BYTES);
                if (w_last_pop && (r_remaining != '0)) begin
                    r_batch     <= f_batch(r_remaining);
                    r_remaining <= r_remaining - LEN_W'(f_batch(r_remaining));
                end
            end
            if (r_state != ST_RD) begin
                r_issued   <= '0;
                r_received <= '0;
            end else begin
                if (w_rd_accept) r_issued <= r_issued + 1'b1;
                r_received <= w_rcv_next;
            end
        end
    end

endmodule

// File: tb/tb_nios_system_mem_copy_master.sv
// Directed and randomized bench for the copy master with an Avalon slave
// memory model and a batch-level reference model of the expected traffic.
module tb_nios_system_mem_copy_master;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] src_addr = '0;
    logic [31:0] dst_addr = '0;
    logic [15:0] len = '0;
    logic        busy, done, m_read, m_write;
    logic [31:0] m_address, m_writedata;
    logic [3:0]  m_byteenable;
    logic        m_waitrequest = 1'b0;
    logic [31:0] m_readdata = '0;
    logic        m_readdatavalid = 1'b0;

    nios_system_mem_copy_master #(
        .ADDR_W     (32),
        .LEN_W      (16),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .start           (start),
        .src_addr        (src_addr),
        .dst_addr        (dst_addr),
        .len             (len),
        .busy            (busy),
        .done            (done),
        .m_address       (m_address),
        .m_read          (m_read),
        .m_write         (m_write),
        .m_byteenable    (m_byteenable),
        .m_writedata     (m_writedata),
        .m_waitrequest   (m_waitrequest),
        .m_readdata      (m_readdata),
        .m_readdatavalid (m_readdatavalid)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    // Slave model state (written only by the slave process below)
    typedef struct { int ready; logic [31:0] data; } rsp_t;
    rsp_t        rq[$];
    logic [31:0] mem [logic [31:0]];
    logic [31:0] rd_log[$];
    logic [31:0] wa_log[$];
    logic [31:0] wd_log[$];
    bit          op_log[$];
    int          stab_viol = 0;
    int          rw_viol = 0;
    int          done_cnt = 0;
    int          last_ready = 0;
    logic        p_rd = 0, p_wr = 0, p_wait = 0;
    logic [31:0] p_addr = '0, p_wd = '0;

    // Knobs written only by the stimulus process
    int          wait_pct = 0;
    int          max_lat = 1;
    logic [31:0] salt = '0;

    function automatic logic [31:0] init_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ salt;
    endfunction

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return init_word(a);
    endfunction

    always @(negedge clk) begin : slave
        int   lat, r;
        rsp_t e;
        if (done) done_cnt++;
        if (!reset_n) begin
            rq.delete();
            m_waitrequest   = 1'b0;
            m_readdatavalid = 1'b0;
            p_rd = 0; p_wr = 0; p_wait = 0;
            last_ready = 0;
        end else begin
            if (p_wait && (p_rd || p_wr) &&
                (m_read !== p_rd || m_write !== p_wr || m_address !== p_addr ||
                 (p_wr && m_writedata !== p_wd)))
                stab_viol++;
            if (m_read && m_write) rw_viol++;
            m_waitrequest = ($urandom_range(99) < wait_pct);
            if (rq.size() > 0 && rq[0].ready <= cyc) begin
                m_readdatavalid = 1'b1;
                m_readdata      = rq[0].data;
                void'(rq.pop_front());
            end else begin
                m_readdatavalid = 1'b0;
                m_readdata      = $urandom;
            end
            if (m_read && !m_waitrequest) begin
                lat = $urandom_range(max_lat, 1);
                r   = cyc + lat;
                if (r <= last_ready) r = last_ready + 1;
                last_ready = r;
                e.ready = r;
                e.data  = mem_rd(m_address);
                rq.push_back(e);
                rd_log.push_back(m_address);
                op_log.push_back(1'b0);
            end
            if (m_write && !m_waitrequest) begin
                mem[m_address] = m_writedata;
                wa_log.push_back(m_address);
                wd_log.push_back(m_writedata);
                op_log.push_back(1'b1);
            end
            p_rd = m_read; p_wr = m_write; p_wait = m_waitrequest;
            p_addr = m_address; p_wd = m_writedata;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic run_copy(input string tag, input logic [31:0] s, input logic [31:0] d,
                            input int n, input int wp, input int ml, input bit restart,
                            input bit chk_lat, output int lat_out, output int busy_hi);
        int rb, wb, ob, sv0, rv0, dc0, t0, tdone, busy_low, errs, rem, b, k, bound;
        bit got;
        logic [31:0] sa, da;
        sa = {s[31:2], 2'b00};
        da = {d[31:2], 2'b00};
        wait_pct = wp; max_lat = ml;
        rb = rd_log.size(); wb = wa_log.size(); ob = op_log.size();
        sv0 = stab_viol; rv0 = rw_viol; dc0 = done_cnt;
        @(negedge clk);
        src_addr = s; dst_addr = d; len = 16'(n); start = 1'b1; t0 = cyc;
        @(negedge clk);
        start = 1'b0;
        got = 0; busy_low = 0; busy_hi = 0; tdone = t0;
        for (int i = 0; i < 4000; i++) begin
            if (busy) busy_hi++; else busy_low++;
            if (done) begin
                got = 1; tdone = cyc;
                chk({tag, "_busy_at_done"}, busy, 1);
                break;
            end
            if (restart && i == 3) begin
                start = 1'b1; src_addr = s + 32'h2000; dst_addr = d + 32'h2000; len = 16'd5;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        lat_out = tdone - t0;
        chk({tag, "_done_seen"}, got, 1);
        chk({tag, "_busy_low_cycles"}, busy_low, 0);
        @(negedge clk);
        chk({tag, "_idle_after_done"}, {busy, done}, 2'b00);
        repeat (4) @(negedge clk);
        chk({tag, "_done_pulses"}, done_cnt - dc0, 1);
        if (chk_lat) begin
            bound = 2 * n + 3 * ((n + DEPTH - 1) / DEPTH) + 2;
            chk({tag, "_latency_in_bound"}, (lat_out <= bound), 1);
        end
        chk({tag, "_read_count"}, rd_log.size() - rb, n);
        chk({tag, "_write_count"}, wa_log.size() - wb, n);
        errs = 0;
        for (int i = 0; i < n; i++) begin
            if (rb + i >= rd_log.size() || rd_log[rb + i] !== sa + 32'(4 * i)) errs++;
            if (wb + i >= wa_log.size() || wa_log[wb + i] !== da + 32'(4 * i) ||
                wd_log[wb + i] !== init_word(sa + 32'(4 * i))) errs++;
        end
        chk({tag, "_addr_data_errs"}, errs, 0);
        errs = 0; rem = n; k = ob;
        while (rem > 0) begin
            b = (rem < DEPTH) ? rem : DEPTH;
            for (int j = 0; j < 2 * b; j++) begin
                if (k >= op_log.size() || op_log[k] !== (j >= b)) errs++;
                k++;
            end
            rem -= b;
        end
        if (op_log.size() != k) errs++;
        chk({tag, "_batch_order_errs"}, errs, 0);
        chk({tag, "_stall_stability_errs"}, stab_viol - sv0, 0);
        chk({tag, "_read_write_overlap"}, rw_viol - rv0, 0);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int lat, bh, wb0, dc, n, wp, ml, errs;
        bit got;
        logic [31:0] s;
        salt = $urandom;

        repeat (3) @(negedge clk);
        chk("reset_outputs", {busy, done, m_read, m_write, m_address, m_writedata}, '0);
        chk("byteenable", m_byteenable, 4'hF);
        reset_n = 1'b1;
        @(negedge clk);

        run_copy("t1", 32'h100, 32'h200, 1, 0, 1, 0, 1, lat, bh);
        chk("t1_dst_word", mem_rd(32'h200), init_word(32'h100));

        run_copy("t2", 32'h1000, 32'h2000, 20, 0, 1, 0, 1, lat, bh);

        run_copy("t3", 32'h3000, 32'h3800, 0, 0, 1, 0, 1, lat, bh);
        chk("t3_done_latency", lat, 2);
        chk("t3_busy_cycles", bh, 2);

        s = 32'h0003_0000 | ({$urandom_range(255)} << 2) | 32'h3;
        run_copy("t4", s, 32'h0004_0001, 33, 50, 4, 0, 0, lat, bh);

        run_copy("t5", 32'h4000, 32'h5000, 12, 0, 1, 1, 1, lat, bh);

        // Abort mid-write-back with an asynchronous reset
        wait_pct = 0; max_lat = 1;
        wb0 = wa_log.size();
        @(negedge clk);
        src_addr = 32'h8000; dst_addr = 32'h9000; len = 16'd16; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        got = 0;
        for (int i = 0; i < 200; i++) begin
            if (m_write) begin got = 1; break; end
            @(negedge clk);
        end
        chk("t6_reached_wr", got, 1);
        repeat (3) @(negedge clk);
        #2 reset_n = 1'b0;
        #1 chk("t6_outputs_zero", {busy, done, m_read, m_write, m_address, m_writedata}, '0);
        dc = done_cnt;
        repeat (5) @(negedge clk);
        chk("t6_no_done", done_cnt - dc, 0);
        chk("t6_partial_writes", wa_log.size() - wb0, 4);
        errs = 0;
        for (int i = 0; i < 4 && wb0 + i < wa_log.size(); i++)
            if (wa_log[wb0 + i] !== 32'h9000 + 32'(4 * i) ||
                wd_log[wb0 + i] !== init_word(32'h8000 + 32'(4 * i))) errs++;
        chk("t6_partial_data_errs", errs, 0);
        reset_n = 1'b1;
        @(negedge clk);
        run_copy("t6b", 32'hA000, 32'hB000, 16, 0, 1, 0, 1, lat, bh);

        run_copy("t7_wrap", 32'hFFFF_FFF4, 32'h000D_0000, 9, 0, 1, 0, 1, lat, bh);

        for (int k = 0; k < 3; k++) begin
            n  = $urandom_range(40, 1);
            wp = $urandom_range(60);
            ml = $urandom_range(4, 1);
            s  = 32'h0010_0000 * (k + 1) + ({$urandom_range(255)} << 2);
            run_copy("rnd", s, s + 32'h0008_0000, n, wp, ml, 0, 0, lat, bh);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
